// File: rtl/pri_arbiter_8.sv
// Eight-requester arbiter: fixed or round-robin priority, registered one-hot grant,
// bounded tenure with a timeout pulse and a mandatory dead cycle between grants.
module pri_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_timeout;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_ptr;
    logic       r_mode;

    logic [2:0] w_fix_id;
    logic [2:0] w_rr_id;
    logic [2:0] w_win_id;
    logic [2:0] w_scan;
    logic       w_release;
    logic       w_force;

    // Highest set index wins; later loop iterations override earlier ones.
    always_comb begin
        w_fix_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) w_fix_id = 3'(i);
        end
    end

    // Scan backwards so the bit closest to r_ptr is assigned last.
    always_comb begin
        w_rr_id = 3'd0;
        w_scan  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_scan = r_ptr + 3'(k);
            if (req[w_scan]) w_rr_id = w_scan;
        end
    end

    assign w_win_id  = mode ? w_rr_id : w_fix_id;
    assign w_release = !req[r_gnt_id];
    assign w_force   = (r_hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= 8'd0;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= 8'd0;
            r_ptr       <= 3'd0;
            r_mode      <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req != 8'd0) begin
                        r_state     <= BUSY;
                        r_gnt       <= 8'd1 << w_win_id;
                        r_gnt_id    <= w_win_id;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= 8'd1;
                        r_mode      <= mode;
                    end
                end
                BUSY: begin
                    if (w_release || w_force) begin
                        r_state     <= IDLE;
                        r_gnt       <= 8'd0;
                        r_gnt_id    <= 3'd0;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= 8'd0;
                        r_timeout   <= !w_release;
                        if (r_mode) r_ptr <= r_gnt_id + 3'd1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_pri_arbiter_8.sv
// Directed self-checking bench for pri_arbiter_8 (MAX_HOLD=4).
module tb_pri_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    pri_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mode     (mode),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expect a grant to id (valid=1) or no grant (valid=0).
    task automatic chk(input string tag, input logic v, input logic [2:0] id,
                       input logic to);
        logic [7:0] eg;
        eg = v ? (8'd1 << id) : 8'd0;
        chk1({tag, ".gnt"}, gnt, eg);
        chk1({tag, ".gnt_id"}, {5'd0, gnt_id}, v ? {5'd0, id} : 8'd0);
        chk1({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, v});
        chk1({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to});
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        mode  = 1'b0;

        // Reset with all requests high
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst", 1'b0, 3'd0, 1'b0);
        end
        rst_n = 1'b1;
        req   = 8'h00;
        step();
        chk("idle0", 1'b0, 3'd0, 1'b0);
        step();
        chk("idle1", 1'b0, 3'd0, 1'b0);

        // Fixed priority
        mode = 1'b0;
        req  = 8'b0010_1100;
        step();
        chk("fix5", 1'b1, 3'd5, 1'b0);
        req = 8'b0000_1100;
        step();
        chk("fixgap", 1'b0, 3'd0, 1'b0);
        step();
        chk("fix3", 1'b1, 3'd3, 1'b0);
        req = 8'h00;
        step();
        chk("fixrel", 1'b0, 3'd0, 1'b0);

        // Round-robin rotation 0..7,0 (ptr still 0 after fixed mode)
        mode = 1'b1;
        req  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr%0d", i), 1'b1, 3'(i), 1'b0);
            req = 8'hFF & ~(8'd1 << (i % 8));
            step();
            chk($sformatf("rrgap%0d", i), 1'b0, 3'd0, 1'b0);
            req = (i == 8) ? 8'h00 : 8'hFF;
        end

        // Timeout at MAX_HOLD=4 in fixed mode (ptr stays 1)
        mode = 1'b0;
        req  = 8'b0000_0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hold%0d", i), 1'b1, 3'd0, 1'b0);
        end
        step();
        chk("tmo", 1'b0, 3'd0, 1'b1);
        step();
        chk("regrant", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        step();
        chk("tmorel", 1'b0, 3'd0, 1'b0);

        // Round-robin wrap: ptr=1 -> grant 5 -> ptr=6
        mode = 1'b1;
        req  = 8'b0010_0000;
        step();
        chk("rw5", 1'b1, 3'd5, 1'b0);
        req = 8'b0000_0001;
        step();
        chk("rwgap0", 1'b0, 3'd0, 1'b0);
        req = 8'b0010_0001;
        step();
        chk("rwwrap0", 1'b1, 3'd0, 1'b0);
        req = 8'b0010_0000;
        step();
        chk("rwgap1", 1'b0, 3'd0, 1'b0);
        step();
        chk("rwfair5", 1'b1, 3'd5, 1'b0);
        req = 8'h00;
        step();
        chk("rwrel", 1'b0, 3'd0, 1'b0);

        // Reset mid-tenure (ptr is 6 before reset)
        mode = 1'b0;
        req  = 8'b0000_1000;
        step();
        chk("mt3a", 1'b1, 3'd3, 1'b0);
        step();
        chk("mt3b", 1'b1, 3'd3, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mtrst", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        mode  = 1'b1;
        req   = 8'b0000_1010;
        step();
        chk("mtrr1", 1'b1, 3'd1, 1'b0);
        req = 8'b0000_1000;
        step();
        chk("mtgap", 1'b0, 3'd0, 1'b0);
        req = 8'b0000_1010;
        step();
        chk("mtrr3", 1'b1, 3'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
